// File: rtl/dac_spi_serializer_if.sv
// Sample handshake between the mixer (master) and the DAC serializer (slave).
interface dac_spi_serializer_if;
   logic [11:0] i_sample;
   logic        i_sample_valid;
   logic        o_ready;

   modport master (output i_sample, output i_sample_valid, input o_ready);
   modport slave  (input i_sample, input i_sample_valid, output o_ready);
endinterface

// File: rtl/dac_spi_serializer.sv
// Shifts {CONFIG_BITS,sample} to an MCP4921-class DAC, SPI mode 0,0, MSB first; DAC_SERIALIZER_LDAC_EN adds an LDAC strobe.
// Frame starts the cycle after accept; ready only in IDLE, samples offered while busy are dropped and flagged on o_overrun.
module dac_spi_serializer #(
   parameter int         CLK_DIV     = 2,
   parameter logic [3:0] CONFIG_BITS = 4'b0011
) (
   input  logic                       i_clock,
   input  logic                       i_reset,
   dac_spi_serializer_if.slave        sample_if,
   output logic                       o_overrun,
   output logic                       o_dac_cs_n,
   output logic                       o_dac_sck,
   output logic                       o_dac_sdi,
   output logic                       o_dac_ldac_n
);

   localparam int             DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
`ifdef DAC_SERIALIZER_LDAC_EN
      S_LDAC,
`endif
      S_CS_HOLD
   } state_t;

   state_t        state;
   logic          ready_q;
   logic          cs_n_q;
   logic          sck_q;
   logic          sdi_q;
   logic [14:0]   shreg;
   logic [5:0]    half_cnt;
   logic [DW-1:0] div_cnt;
   logic [5:0]    half_nxt;

   assign half_nxt          = half_cnt + 6'd1;
   assign sample_if.o_ready = ready_q;
   assign o_overrun         = sample_if.i_sample_valid & ~ready_q & ~i_reset;
   assign o_dac_cs_n        = cs_n_q;
   assign o_dac_sck         = sck_q;
   assign o_dac_sdi         = sdi_q;

`ifdef DAC_SERIALIZER_LDAC_EN
   logic ldac_n_q;
   assign o_dac_ldac_n = ldac_n_q;
`else
   assign o_dac_ldac_n = 1'b0;
`endif

   // Half-period 0 is the sck-low setup; odd halves are sck high, even halves low.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state    <= S_IDLE;
         ready_q  <= 1'b1;
         cs_n_q   <= 1'b1;
         sck_q    <= 1'b0;
         sdi_q    <= 1'b0;
         shreg    <= '0;
         half_cnt <= '0;
         div_cnt  <= '0;
`ifdef DAC_SERIALIZER_LDAC_EN
         ldac_n_q <= 1'b1;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (sample_if.i_sample_valid) begin
                  shreg    <= {CONFIG_BITS[2:0], sample_if.i_sample};
                  sdi_q    <= CONFIG_BITS[3];
                  cs_n_q   <= 1'b0;
                  sck_q    <= 1'b0;
                  ready_q  <= 1'b0;
                  half_cnt <= '0;
                  div_cnt  <= '0;
                  state    <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  if (half_cnt == 6'd32) begin
                     cs_n_q <= 1'b1;
                     sck_q  <= 1'b0;
                     sdi_q  <= 1'b0;
                     state  <= S_CS_HOLD;
                  end else begin
                     half_cnt <= half_nxt;
                     sck_q    <= half_nxt[0];
                     // Falling edges into halves 2..30 advance; bit0 holds through the last low half.
                     if (!half_nxt[0] && (half_nxt <= 6'd30)) begin
                        sdi_q <= shreg[14];
                        shreg <= {shreg[13:0], 1'b0};
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            S_CS_HOLD: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
`ifdef DAC_SERIALIZER_LDAC_EN
                  ldac_n_q <= 1'b0;
                  state    <= S_LDAC;
`else
                  ready_q  <= 1'b1;
                  state    <= S_IDLE;
`endif
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
`ifdef DAC_SERIALIZER_LDAC_EN
            S_LDAC: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt  <= '0;
                  ldac_n_q <= 1'b1;
                  ready_q  <= 1'b1;
                  state    <= S_IDLE;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
